// File: rtl/cache_refill_unit.sv
// Cache line refill engine: accepts one miss, fetches a 16-beat line from memory,
// and hands the assembled line to the cache with a round-robin victim way per set.
module cache_refill_unit #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         miss_valid,
    output logic         miss_ready,
    input  logic [31:0]  miss_addr,
    input  logic [31:0]  miss_pc,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic [31:0]  mem_req_addr,
    input  logic         mem_resp_valid,
    input  logic [31:0]  mem_resp_data,
    output logic         refill_valid,
    input  logic         refill_ready,
    output logic [18:0]  refill_tag,
    output logic [6:0]   refill_index,
    output logic [1:0]   refill_way,
    output logic [511:0] refill_data,
    output logic [31:0]  refill_pc,
    output logic         refill_err,
    output logic         busy
);

    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, COLLECT, REFILL} state_t;

    state_t         state, state_nxt;
    logic [25:0]    line_q;
    logic [31:0]    pc_q;
    logic [3:0]     beat_cnt;
    logic [IW-1:0]  idle_cnt;
    logic [511:0]   line_buf;
    logic [1:0]     ptr [128];
    logic           err_q;

    logic accept, req_hs, beat, last_beat, timeout_hit, refill_hs;
    logic unused_offset;

    always_comb begin
        state_nxt     = state;
        miss_ready    = (state == IDLE);
        mem_req_valid = (state == REQ);
        refill_valid  = (state == REFILL);
        busy          = (state != IDLE);
        accept        = miss_valid && (state == IDLE);
        req_hs        = (state == REQ) && mem_req_ready;
        beat          = (state == COLLECT) && mem_resp_valid;
        last_beat     = beat && (beat_cnt == 4'd15);
        // A beat arriving on the final idle cycle still counts, so only abort when silent.
        timeout_hit   = (state == COLLECT) && !mem_resp_valid && (idle_cnt == IW'(TIMEOUT - 1));
        refill_hs     = (state == REFILL) && refill_ready;

        case (state)
            IDLE:    if (accept)      state_nxt = REQ;
            REQ:     if (req_hs)      state_nxt = COLLECT;
            COLLECT: if (last_beat)   state_nxt = REFILL;
                     else if (timeout_hit) state_nxt = IDLE;
            REFILL:  if (refill_hs)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase

        mem_req_addr  = {line_q, 6'b0};
        refill_tag    = line_q[25:7];
        refill_index  = line_q[6:0];
        refill_way    = ptr[line_q[6:0]];
        refill_data   = line_buf;
        refill_pc     = pc_q;
        refill_err    = err_q;
        unused_offset = ^miss_addr[5:0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            line_q   <= '0;
            pc_q     <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
            line_buf <= '0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < 128; i++) begin
                ptr[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            err_q <= timeout_hit;

            if (accept) begin
                line_q <= miss_addr[31:6];
                pc_q   <= miss_pc;
            end

            if (req_hs) begin
                beat_cnt <= '0;
                idle_cnt <= '0;
                line_buf <= '0;
            end

            if (beat) begin
                line_buf[{beat_cnt, 5'd0} +: 32] <= mem_resp_data;
                beat_cnt <= beat_cnt + 1'b1;
                idle_cnt <= '0;
            end else if (timeout_hit) begin
                beat_cnt <= '0;
                idle_cnt <= '0;
                line_buf <= '0;
            end else if (state == COLLECT) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (refill_hs) begin
                ptr[line_q[6:0]] <= ptr[line_q[6:0]] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_refill_unit.sv
// Directed self-checking bench for cache_refill_unit.
module tb_cache_refill_unit;

    logic         clk;
    logic         rstn;
    logic         miss_valid;
    logic         miss_ready;
    logic [31:0]  miss_addr;
    logic [31:0]  miss_pc;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_resp_valid;
    logic [31:0]  mem_resp_data;
    logic         refill_valid;
    logic         refill_ready;
    logic [18:0]  refill_tag;
    logic [6:0]   refill_index;
    logic [1:0]   refill_way;
    logic [511:0] refill_data;
    logic [31:0]  refill_pc;
    logic         refill_err;
    logic         busy;

    int total;
    int bad;

    cache_refill_unit #(.TIMEOUT(64)) dut (
        .clk(clk),
        .rstn(rstn),
        .miss_valid(miss_valid),
        .miss_ready(miss_ready),
        .miss_addr(miss_addr),
        .miss_pc(miss_pc),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data),
        .refill_valid(refill_valid),
        .refill_ready(refill_ready),
        .refill_tag(refill_tag),
        .refill_index(refill_index),
        .refill_way(refill_way),
        .refill_data(refill_data),
        .refill_pc(refill_pc),
        .refill_err(refill_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [31:0] base);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    // Accept a miss, grant the request at once, stream 16 beats back-to-back.
    // Leaves the DUT in REFILL with refill_ready low.
    task automatic run_refill(input logic [31:0] addr, input logic [31:0] pc, input logic [31:0] base);
        miss_valid    = 1'b1;
        miss_addr     = addr;
        miss_pc       = pc;
        mem_req_ready = 1'b1;
        tick();
        miss_valid = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + 32'(k);
            if (k == 15) chk("pre_refill_low", {511'b0, refill_valid}, 512'd0);
            tick();
        end
        mem_resp_valid = 1'b0;
        chk("refill_valid_cycle18", {511'b0, refill_valid}, 512'd1);
    endtask

    task automatic handshake();
        refill_ready = 1'b1;
        tick();
        refill_ready = 1'b0;
    endtask

    initial begin
        logic [511:0] snap;
        total = 0;
        bad   = 0;
        rstn = 1'b0; miss_valid = 1'b0; miss_addr = '0; miss_pc = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; refill_ready = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();

        chk("rst_miss_ready", {511'b0, miss_ready}, 512'd1);
        chk("rst_busy", {511'b0, busy}, 512'd0);
        chk("rst_mem_req_valid", {511'b0, mem_req_valid}, 512'd0);
        chk("rst_refill_valid", {511'b0, refill_valid}, 512'd0);
        chk("rst_refill_err", {511'b0, refill_err}, 512'd0);
        chk("rst_tag", {493'b0, refill_tag}, 512'd0);
        chk("rst_index", {505'b0, refill_index}, 512'd0);
        chk("rst_way", {510'b0, refill_way}, 512'd0);
        chk("rst_data", refill_data, 512'd0);
        chk("rst_pc", {480'b0, refill_pc}, 512'd0);

        // Basic line fill, minimum latency
        run_refill(32'h0000_2040, 32'h1000_0004, 32'h0);
        chk("a_tag", {493'b0, refill_tag}, 512'h1);
        chk("a_index", {505'b0, refill_index}, 512'h1);
        chk("a_way", {510'b0, refill_way}, 512'd0);
        chk("a_data", refill_data, mk_line(32'h0));
        chk("a_pc", {480'b0, refill_pc}, 512'h1000_0004);
        chk("a_busy", {511'b0, busy}, 512'd1);

        // Refill stalled 5 cycles while another miss waits
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_4040;
        miss_pc    = 32'h2000_0000;
        snap = refill_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_refill_valid", {511'b0, refill_valid}, 512'd1);
            chk("stall_miss_ready", {511'b0, miss_ready}, 512'd0);
            chk("stall_data", refill_data, snap);
            chk("stall_tag", {493'b0, refill_tag}, 512'h1);
        end
        handshake();
        chk("post_hs_idle", {511'b0, busy}, 512'd0);
        chk("post_hs_miss_ready", {511'b0, miss_ready}, 512'd1);
        tick();
        miss_valid = 1'b0;
        chk("second_accept", {511'b0, mem_req_valid}, 512'd1);
        chk("second_addr", {480'b0, mem_req_addr}, 512'h0000_4040);

        // 8 beats then silence -> timeout abort
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hA0 + 32'(k);
            tick();
        end
        mem_resp_valid = 1'b0;
        for (int i = 1; i < 64; i++) begin
            tick();
            chk("to_no_err_early", {510'b0, refill_err, busy}, 512'd1);
        end
        tick();
        chk("to_err_pulse", {511'b0, refill_err}, 512'd1);
        chk("to_idle", {511'b0, busy}, 512'd0);
        chk("to_no_refill", {511'b0, refill_valid}, 512'd0);
        tick();
        chk("to_err_one_cycle", {511'b0, refill_err}, 512'd0);

        // Request held off 10 cycles, stray beats presented meanwhile
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_6040;
        miss_pc    = 32'h3000_0008;
        tick();
        miss_valid = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            chk("hold_req_valid", {511'b0, mem_req_valid}, 512'd1);
            chk("hold_req_addr", {480'b0, mem_req_addr}, 512'h0000_6040);
            tick();
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'h100 + 32'(k);
            chk("hold_no_early_refill", {511'b0, refill_valid}, 512'd0);
            tick();
        end
        mem_resp_valid = 1'b0;
        chk("c_refill_valid", {511'b0, refill_valid}, 512'd1);
        chk("c_tag", {493'b0, refill_tag}, 512'h3);
        chk("c_way_after_abort", {510'b0, refill_way}, 512'd1);
        chk("c_data", refill_data, mk_line(32'h100));
        chk("c_pc", {480'b0, refill_pc}, 512'h3000_0008);
        handshake();

        // Round-robin on set 5, then a fresh set
        for (int t = 0; t < 5; t++) begin
            run_refill(32'h0000_0140 + 32'(t) * 32'h2000, 32'h4000_0000 + 32'(t), 32'h300);
            chk("rr_index", {505'b0, refill_index}, 512'h5);
            chk("rr_way", {510'b0, refill_way}, 512'(t % 4));
            handshake();
        end
        run_refill(32'h0000_0180, 32'h5000_0000, 32'h400);
        chk("rr_set6_way", {510'b0, refill_way}, 512'd0);
        chk("rr_set6_index", {505'b0, refill_index}, 512'h6);
        handshake();

        // Reset during COLLECT after 7 beats
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_0140;
        miss_pc    = 32'h6000_0000;
        mem_req_ready = 1'b1;
        tick();
        miss_valid = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'h500 + 32'(k);
            tick();
        end
        rstn = 1'b0;
        tick();
        mem_resp_valid = 1'b0;
        chk("mrst_busy", {511'b0, busy}, 512'd0);
        chk("mrst_miss_ready", {511'b0, miss_ready}, 512'd1);
        chk("mrst_req_valid", {511'b0, mem_req_valid}, 512'd0);
        chk("mrst_refill_valid", {511'b0, refill_valid}, 512'd0);
        chk("mrst_err", {511'b0, refill_err}, 512'd0);
        chk("mrst_tag", {493'b0, refill_tag}, 512'd0);
        chk("mrst_index", {505'b0, refill_index}, 512'd0);
        chk("mrst_data", refill_data, 512'd0);
        chk("mrst_pc", {480'b0, refill_pc}, 512'd0);
        rstn = 1'b1;
        tick();
        chk("mrst_no_err_after", {511'b0, refill_err}, 512'd0);
        run_refill(32'h0000_0140, 32'h6000_0004, 32'h600);
        chk("mrst_way_reset", {510'b0, refill_way}, 512'd0);
        chk("mrst_data_fresh", refill_data, mk_line(32'h600));
        chk("mrst_pc_fresh", {480'b0, refill_pc}, 512'h6000_0004);
        handshake();
        chk("final_idle", {511'b0, busy}, 512'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
